// File: rtl/mem_handshake_responder_if.sv
// ----------------------------------------------------------------------------
// mem_handshake_responder_if
//
// Purpose: bundles the MOV/MOC memory handshake between the control unit /
//          MAR-MDR side (master) and the memory responder (slave).
//
// Signals:
//   MOV     master->slave  memory operation valid (request)
//   RW      master->slave  1 = read, 0 = write
//   Addr    master->slave  byte address (MAR), 32 bits
//   DataIn  master->slave  write data (MDR), 32 bits
//   Opcode  master->slave  access size / signedness, 6 bits
//   DataOut slave->master  registered read data, 32 bits
//   MOC     slave->master  memory operation complete
//   Fault   slave->master  misaligned-access flag
// ----------------------------------------------------------------------------
interface mem_handshake_responder_if;
    logic        MOV;
    logic        RW;
    logic [31:0] Addr;
    logic [31:0] DataIn;
    logic [5:0]  Opcode;
    logic [31:0] DataOut;
    logic        MOC;
    logic        Fault;

    modport master (
        output MOV, RW, Addr, DataIn, Opcode,
        input  DataOut, MOC, Fault
    );

    modport slave (
        input  MOV, RW, Addr, DataIn, Opcode,
        output DataOut, MOC, Fault
    );
endinterface

// File: rtl/mem_handshake_responder.sv
// ----------------------------------------------------------------------------
// mem_handshake_responder
//
// Purpose: cycle-accurate memory responder for the MOV/MOC handshake.
//          Byte-addressed DEPTH x 8 storage, big-endian, byte / halfword /
//          word accesses selected by Opcode. Request operands are latched on
//          the accept edge; MOC rises LATENCY+1 edges after that edge and is
//          held (with DataOut) until MOV is seen low.
//
// Ports:
//   Clk  in   rising-edge clock
//   Clr  in   asynchronous active-high reset (storage is not cleared)
//   bus  slave modport of mem_handshake_responder_if
//        (MOV, RW, Addr, DataIn, Opcode in; DataOut, MOC, Fault out)
//
// Parameters:
//   LATENCY  wait cycles between accept and MOC (1..15)
//   DEPTH    bytes of storage; must be a power of two (addresses wrap)
//
// Configuration:
//   MEM_ALIGN_CHECK_EN  when defined, misaligned halfword/word accesses are
//                       flagged on Fault and do not touch storage/DataOut.
//                       When undefined, Fault is constant 0 and unaligned
//                       accesses proceed byte-wise with wrap-around.
// ----------------------------------------------------------------------------
module mem_handshake_responder #(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 512
) (
    input  logic                      Clk,
    input  logic                      Clr,
    mem_handshake_responder_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           moc_q, moc_d;
    logic [31:0]    dout_q, dout_d;
    logic           fault_q, fault_d;

    // Request operands captured on the accept edge.
    logic           lat_rw_q;
    logic [AW-1:0]  lat_addr_q;
    logic [31:0]    lat_data_q;
    logic [5:0]     lat_op_q;

    logic           accept;
    logic           do_write;
    size_t          size;
    logic           sext;
    logic           misaligned;
    logic [AW-1:0]  a0, a1, a2, a3;
    logic [31:0]    rd_data;
    logic [31:0]    wr_bytes;  // [31:24] -> a0 ... [7:0] -> a3
    logic [3:0]     byte_en;   // [3] -> a0 ... [0] -> a3

    logic [7:0]     mem [DEPTH];

    // Upper address bits are outside the storage window by design.
    logic           unused_addr_hi;
    assign unused_addr_hi = ^bus.Addr[31:AW];

    // Byte lanes of the access; AW-bit addition wraps modulo DEPTH.
    assign a0 = lat_addr_q;
    assign a1 = lat_addr_q + AW'(1);
    assign a2 = lat_addr_q + AW'(2);
    assign a3 = lat_addr_q + AW'(3);

    // Size/extension decode. RW alone picks direction, so store opcodes
    // used with RW=1 read zero-extended data of their size.
    always_comb begin
        // NOTE: every variable written in a combinational block gets a
        // default first, so no path can leave it unassigned and infer a latch.
        size = SZ_WORD;
        sext = 1'b0;
        unique case (lat_op_q)
            OP_LB:          begin size = SZ_BYTE; sext = 1'b1; end
            OP_LBU, OP_SB:  size = SZ_BYTE;
            OP_LH:          begin size = SZ_HALF; sext = 1'b1; end
            OP_LHU, OP_SH:  size = SZ_HALF;
            default:        size = SZ_WORD;
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = ((size == SZ_HALF) && lat_addr_q[0]) ||
                        ((size == SZ_WORD) && (lat_addr_q[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // Big-endian read assembly: lowest address holds the most significant byte.
    always_comb begin
        rd_data = '0;
        unique case (size)
            SZ_BYTE: rd_data = {{24{sext & mem[a0][7]}}, mem[a0]};
            SZ_HALF: rd_data = {{16{sext & mem[a0][7]}}, mem[a0], mem[a1]};
            default: rd_data = {mem[a0], mem[a1], mem[a2], mem[a3]};
        endcase
    end

    // Store data is taken from the low bits of DataIn and left-aligned onto
    // the lanes so lane a0 always receives the most significant stored byte.
    always_comb begin
        wr_bytes = lat_data_q;
        byte_en  = 4'b1111;
        unique case (size)
            SZ_BYTE: begin wr_bytes = {lat_data_q[7:0], 24'h0};  byte_en = 4'b1000; end
            SZ_HALF: begin wr_bytes = {lat_data_q[15:0], 16'h0}; byte_en = 4'b1100; end
            default: begin wr_bytes = lat_data_q;                byte_en = 4'b1111; end
        endcase
    end

    // Next-state and output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        moc_d    = moc_q;
        dout_d   = dout_q;
        fault_d  = fault_q;
        accept   = 1'b0;
        do_write = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.MOV) begin
                    accept  = 1'b1;
                    // Counts the BUSY edges left before the access edge, so
                    // MOC lands LATENCY+1 edges after the accept edge.
                    cnt_d   = 4'(LATENCY);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    moc_d   = 1'b1;
                    fault_d = misaligned;
                    if (!misaligned) begin
                        if (lat_rw_q) dout_d   = rd_data;
                        else          do_write = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                // MOV already low here (dropped during BUSY) gives a
                // one-cycle MOC pulse.
                if (!bus.MOV) begin
                    state_d = IDLE;
                    moc_d   = 1'b0;
                    fault_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            moc_q      <= 1'b0;
            dout_q     <= '0;
            fault_q    <= 1'b0;
            lat_rw_q   <= 1'b0;
            lat_addr_q <= '0;
            lat_data_q <= '0;
            lat_op_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            moc_q   <= moc_d;
            dout_q  <= dout_d;
            fault_q <= fault_d;
            if (accept) begin
                lat_rw_q   <= bus.RW;
                lat_addr_q <= bus.Addr[AW-1:0];
                lat_data_q <= bus.DataIn;
                lat_op_q   <= bus.Opcode;
            end
        end
    end

    // NOTE: the storage array has no reset; contents survive Clr and it can
    // map onto RAM. A write aborted by Clr never commits because Clr forces
    // the FSM out of BUSY, which deasserts do_write.
    always_ff @(posedge Clk) begin
        if (do_write) begin
            if (byte_en[3]) mem[a0] <= wr_bytes[31:24];
            if (byte_en[2]) mem[a1] <= wr_bytes[23:16];
            if (byte_en[1]) mem[a2] <= wr_bytes[15:8];
            if (byte_en[0]) mem[a3] <= wr_bytes[7:0];
        end
    end

    assign bus.MOC     = moc_q;
    assign bus.DataOut = dout_q;
    assign bus.Fault   = fault_q;

endmodule

// File: tb/tb_mem_handshake_responder.sv
// ----------------------------------------------------------------------------
// tb_mem_handshake_responder
//
// Purpose: self-checking bench for mem_handshake_responder. Each transfer
//          pushes its expected DataOut/Fault to a scoreboard when driven;
//          the entry is popped and compared when MOC rises.
// ----------------------------------------------------------------------------
module tb_mem_handshake_responder;

    localparam int LAT = 2;

    localparam logic [5:0] LB  = 6'b100000;
    localparam logic [5:0] LBU = 6'b100100;
    localparam logic [5:0] LH  = 6'b100001;
    localparam logic [5:0] LHU = 6'b100101;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] SB  = 6'b101000;
    localparam logic [5:0] SH  = 6'b101001;
    localparam logic [5:0] SW  = 6'b101011;

    typedef struct {
        logic [31:0] dout;
        logic        fault;
    } exp_t;

    logic Clk = 1'b0;
    logic Clr;

    mem_handshake_responder_if bus ();

    mem_handshake_responder #(.LATENCY(LAT), .DEPTH(512)) dut (
        .Clk (Clk),
        .Clr (Clr),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    int          checks   = 0;
    int          failures = 0;
    exp_t        sb[$];
    logic [31:0] model_dout = 32'h0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // One complete transfer. hold = extra DONE cycles with MOV high;
    // drop_early releases MOV right after accept (MOC must pulse one cycle).
    task automatic xfer(input string tag, input logic rw, input logic [31:0] addr,
                        input logic [31:0] data, input logic [5:0] op,
                        input logic [31:0] exp_rd, input logic exp_flt,
                        input int hold, input bit drop_early);
        exp_t e;
        int   edges;
        if (rw && !exp_flt) model_dout = exp_rd;
        e.dout  = model_dout;
        e.fault = exp_flt;
        sb.push_back(e);

        @(negedge Clk);
        bus.MOV    = 1'b1;
        bus.RW     = rw;
        bus.Addr   = addr;
        bus.DataIn = data;
        bus.Opcode = op;
        @(posedge Clk); #1;
        // Operands were latched on that edge; disturb the live inputs.
        bus.Addr   = ~addr;
        bus.DataIn = ~data;
        bus.Opcode = 6'b000000;
        bus.RW     = ~rw;
        if (drop_early) bus.MOV = 1'b0;

        edges = 0;
        while (bus.MOC !== 1'b1 && edges < 40) begin
            @(posedge Clk); #1;
            edges++;
        end
        check({tag, "_latency"}, 32'(edges), 32'(LAT + 1));
        if (bus.MOC === 1'b1) begin
            e = sb.pop_front();
            check({tag, "_dout"}, bus.DataOut, e.dout);
            check({tag, "_fault"}, 32'(bus.Fault), 32'(e.fault));
        end

        if (!drop_early) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge Clk); #1;
                check({tag, "_moc_hold"}, 32'(bus.MOC), 32'd1);
            end
            @(negedge Clk);
            bus.MOV = 1'b0;
        end
        @(posedge Clk); #1;
        check({tag, "_moc_fall"}, 32'(bus.MOC), 32'd0);
        check({tag, "_fault_fall"}, 32'(bus.Fault), 32'd0);
        check({tag, "_dout_keep"}, bus.DataOut, model_dout);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Clr        = 1'b1;
        bus.MOV    = 1'b0;
        bus.RW     = 1'b0;
        bus.Addr   = '0;
        bus.DataIn = '0;
        bus.Opcode = '0;
        repeat (2) @(posedge Clk);
        #1;
        check("reset_moc",   32'(bus.MOC),   32'd0);
        check("reset_dout",  bus.DataOut,    32'h0);
        check("reset_fault", 32'(bus.Fault), 32'd0);
        @(negedge Clk);
        Clr = 1'b0;

        // Word store/load and big-endian byte order.
        xfer("sw_10",  1'b0, 32'h10, 32'hDEADBEEF, SW,  32'h0,        1'b0, 0, 1'b0);
        xfer("lw_10",  1'b1, 32'h10, 32'h0,        LW,  32'hDEADBEEF, 1'b0, 0, 1'b0);
        xfer("lbu_10", 1'b1, 32'h10, 32'h0,        LBU, 32'h000000DE, 1'b0, 0, 1'b0);
        xfer("lbu_13", 1'b1, 32'h13, 32'h0,        LBU, 32'h000000EF, 1'b0, 0, 1'b0);

        // Byte store, signed / unsigned byte load.
        xfer("sb_21",  1'b0, 32'h21, 32'h00000080, SB,  32'h0,        1'b0, 0, 1'b0);
        xfer("lb_21",  1'b1, 32'h21, 32'h0,        LB,  32'hFFFFFF80, 1'b0, 0, 1'b0);
        xfer("lbu_21", 1'b1, 32'h21, 32'h0,        LBU, 32'h00000080, 1'b0, 0, 1'b0);

        // Halfword store, signed / unsigned halfword load.
        xfer("sh_30",  1'b0, 32'h30, 32'h0000F00D, SH,  32'h0,        1'b0, 0, 1'b0);
        xfer("lh_30",  1'b1, 32'h30, 32'h0,        LH,  32'hFFFFF00D, 1'b0, 0, 1'b0);
        xfer("lhu_30", 1'b1, 32'h30, 32'h0,        LHU, 32'h0000F00D, 1'b0, 0, 1'b0);
        xfer("lbu_31", 1'b1, 32'h31, 32'h0,        LBU, 32'h0000000D, 1'b0, 0, 1'b0);

        // MOV dropped during BUSY: transfer completes, MOC pulses one cycle.
        xfer("lw_drop", 1'b1, 32'h10, 32'h0, LW, 32'hDEADBEEF, 1'b0, 0, 1'b1);

`ifndef MEM_ALIGN_CHECK_EN
        // Unaligned word across the top of storage wraps to address 0;
        // MOC held while MOV stays high in DONE.
        xfer("sw_1fe",  1'b0, 32'h1FE, 32'h11223344, SW,  32'h0,        1'b0, 5, 1'b0);
        xfer("lbu_1fe", 1'b1, 32'h1FE, 32'h0,        LBU, 32'h00000011, 1'b0, 0, 1'b0);
        xfer("lbu_1ff", 1'b1, 32'h1FF, 32'h0,        LBU, 32'h00000022, 1'b0, 0, 1'b0);
        xfer("lbu_000", 1'b1, 32'h000, 32'h0,        LBU, 32'h00000033, 1'b0, 0, 1'b0);
        xfer("lbu_001", 1'b1, 32'h001, 32'h0,        LBU, 32'h00000044, 1'b0, 0, 1'b0);
        xfer("lw_1fe",  1'b1, 32'h1FE, 32'h0,        LW,  32'h11223344, 1'b0, 0, 1'b0);
`endif

        // Reset during BUSY aborts a pending write.
        xfer("sw_40",   1'b0, 32'h40, 32'h12345678, SW, 32'h0,        1'b0, 0, 1'b0);
        xfer("lw_40",   1'b1, 32'h40, 32'h0,        LW, 32'h12345678, 1'b0, 0, 1'b0);
        @(negedge Clk);
        bus.MOV    = 1'b1;
        bus.RW     = 1'b0;
        bus.Addr   = 32'h40;
        bus.DataIn = 32'hAAAAAAAA;
        bus.Opcode = SW;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        Clr     = 1'b1;
        bus.MOV = 1'b0;
        #1;
        check("clr_busy_moc",   32'(bus.MOC),   32'd0);
        check("clr_busy_dout",  bus.DataOut,    32'h0);
        check("clr_busy_fault", 32'(bus.Fault), 32'd0);
        model_dout = 32'h0;
        @(negedge Clk);
        Clr = 1'b0;
        xfer("lw_40_post", 1'b1, 32'h40, 32'h0, LW, 32'h12345678, 1'b0, 0, 1'b0);

`ifdef MEM_ALIGN_CHECK_EN
        // Misaligned accesses fault; storage and DataOut stay untouched.
        xfer("lw_42_flt", 1'b1, 32'h42, 32'h0,        LW, 32'h0,        1'b1, 0, 1'b0);
        xfer("sw_43_flt", 1'b0, 32'h43, 32'hFFFFFFFF, SW, 32'h0,        1'b1, 0, 1'b0);
        xfer("lh_41_flt", 1'b1, 32'h41, 32'h0,        LH, 32'h0,        1'b1, 0, 1'b0);
        xfer("lw_40_chk", 1'b1, 32'h40, 32'h0,        LW, 32'h12345678, 1'b0, 0, 1'b0);
        xfer("lw_44_chk", 1'b1, 32'h44, 32'h0,        LBU, 32'h00000000, 1'b0, 0, 1'b0);
`endif

        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
